// File: rtl/note_scheduler_if.sv
// Scheduler-side bundle: controller inputs, chart ROM port, spawn and slot-occupancy outputs.
// miss_count exists only when NOTE_SCHED_MISS_CNT_EN is defined.
interface note_scheduler_if #(
  parameter int ADDR_W    = 8,
  parameter int TIME_W    = 32,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
);
  logic                 start;
  logic                 game_active;
  logic [TIME_W-1:0]    song_timer;
  logic [ADDR_W-1:0]    rom_addr;
  logic [TIME_W+3:0]    rom_data;
  logic [NUM_SLOTS-1:0] slot_release;
  logic                 spawn_valid;
  logic [SLOT_W-1:0]    spawn_slot;
  logic [3:0]           spawn_lanes;
  logic [TIME_W-1:0]    spawn_time;
  logic [NUM_SLOTS-1:0] slots_busy;
  logic                 chart_done;
`ifdef NOTE_SCHED_MISS_CNT_EN
  logic [15:0]          miss_count;
`endif

  modport master (
    input  start, game_active, song_timer, rom_data, slot_release,
    output rom_addr, spawn_valid, spawn_slot, spawn_lanes, spawn_time, slots_busy, chart_done
`ifdef NOTE_SCHED_MISS_CNT_EN
    , output miss_count
`endif
  );

  modport slave (
    output start, game_active, song_timer, rom_data, slot_release,
    input  rom_addr, spawn_valid, spawn_slot, spawn_lanes, spawn_time, slots_busy, chart_done
`ifdef NOTE_SCHED_MISS_CNT_EN
    , input miss_count
`endif
  );
endinterface

// File: rtl/note_scheduler.sv
// Chart sequencer: fetches {hit_time, lanes}, spawns each note LEAD_TICKS early into the lowest free slot.
// Spawn pulse 4 cycles after start, one spawn per 3 cycles; stalls in CHECK on pause/no slot (NOTE_SCHED_MISS_CNT_EN drops late notes).
module note_scheduler #(
  parameter int CHART_DEPTH = 256,
  parameter int ADDR_W      = 8,
  parameter int TIME_W      = 32,
  parameter int LEAD_TICKS  = 100_000_000,
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_W      = 3
) (
  input  logic               i_clock,
  input  logic               i_resetn,
  note_scheduler_if.master   io_sched
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [TIME_W:0]   LC_LEAD = (TIME_W + 1)'(LEAD_TICKS);
  localparam logic [ADDR_W-1:0] LC_LAST = ADDR_W'(CHART_DEPTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [TIME_W-1:0]    r_hit;
  logic [3:0]           r_lanes;
  logic [NUM_SLOTS-1:0] r_busy;
  logic                 r_spawn_vld;
  logic [SLOT_W-1:0]    r_spawn_slot;
  logic [3:0]           r_spawn_lanes;
  logic [TIME_W-1:0]    r_spawn_time;
  logic                 r_done;
`ifdef NOTE_SCHED_MISS_CNT_EN
  logic [15:0]          r_miss;
`endif

  logic [TIME_W:0]      w_deadline;
  logic                 w_due;
  logic                 w_term;
  logic                 w_any_free;
  logic [SLOT_W-1:0]    w_alloc_slot;
  logic [NUM_SLOTS-1:0] w_alloc_mask;
  logic                 w_spawn;
  logic                 w_drop;
  logic                 w_advance;
  logic                 w_last;

  // Slot choice uses the pre-release occupancy so a same-cycle release never feeds an allocation.
  always_comb begin
    w_any_free   = |(~r_busy);
    w_alloc_slot = '0;
    w_alloc_mask = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_alloc_slot = SLOT_W'(i);
    end
    if (w_any_free) w_alloc_mask[w_alloc_slot] = 1'b1;
  end

  always_comb begin
    w_deadline = {1'b0, io_sched.song_timer} + LC_LEAD;
    w_due      = ({1'b0, r_hit} <= w_deadline);
    w_term     = (r_lanes == 4'd0);
    w_last     = (r_addr == LC_LAST);
    w_spawn    = (r_state == S_CHECK) && !w_term && w_due && io_sched.game_active && w_any_free;
`ifdef NOTE_SCHED_MISS_CNT_EN
    w_drop     = (r_state == S_CHECK) && !w_term && w_due && io_sched.game_active && !w_any_free
                 && (io_sched.song_timer > r_hit);
`else
    w_drop     = 1'b0;
`endif
    w_advance  = w_spawn || w_drop;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_term)         w_state_nxt = S_DONE;
        else if (w_advance) w_state_nxt = w_last ? S_DONE : S_FETCH;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (io_sched.start) w_state_nxt = S_FETCH;
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_addr        <= '0;
      r_hit         <= '0;
      r_lanes       <= '0;
      r_busy        <= '0;
      r_spawn_vld   <= 1'b0;
      r_spawn_slot  <= '0;
      r_spawn_lanes <= '0;
      r_spawn_time  <= '0;
      r_done        <= 1'b0;
`ifdef NOTE_SCHED_MISS_CNT_EN
      r_miss        <= '0;
`endif
    end else if (io_sched.start) begin
      r_addr      <= '0;
      r_busy      <= '0;
      r_spawn_vld <= 1'b0;
      r_done      <= 1'b0;
`ifdef NOTE_SCHED_MISS_CNT_EN
      r_miss      <= '0;
`endif
    end else begin
      r_spawn_vld <= w_spawn;
      r_busy      <= (r_busy & ~io_sched.slot_release) | (w_spawn ? w_alloc_mask : '0);
      if (w_spawn) begin
        r_spawn_slot  <= w_alloc_slot;
        r_spawn_lanes <= r_lanes;
        r_spawn_time  <= r_hit;
      end
      if (r_state == S_WAIT) begin
        r_hit   <= io_sched.rom_data[TIME_W+3:4];
        r_lanes <= io_sched.rom_data[3:0];
      end
      if (w_advance && !w_last) r_addr <= r_addr + ADDR_W'(1);
      if ((r_state == S_CHECK) && (w_term || (w_advance && w_last))) r_done <= 1'b1;
`ifdef NOTE_SCHED_MISS_CNT_EN
      if (w_drop && (r_miss != 16'hFFFF)) r_miss <= r_miss + 16'd1;
`endif
    end
  end

  assign io_sched.rom_addr    = r_addr;
  assign io_sched.spawn_valid = r_spawn_vld;
  assign io_sched.spawn_slot  = r_spawn_slot;
  assign io_sched.spawn_lanes = r_spawn_lanes;
  assign io_sched.spawn_time  = r_spawn_time;
  assign io_sched.slots_busy  = r_busy;
  assign io_sched.chart_done  = r_done;
`ifdef NOTE_SCHED_MISS_CNT_EN
  assign io_sched.miss_count  = r_miss;
`endif

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: 2 slots, LEAD_TICKS=100, chart {500,0001},{500,0100},{520,1000},{0,0}.
// Inputs driven and outputs sampled on the falling edge; rom model is a 1-cycle synchronous read.
module tb_note_scheduler;
  localparam int ADDR_W = 3;
  localparam int TIME_W = 32;
  localparam int NSLOT  = 2;
  localparam int SLOTW  = 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n;
  bit   found;

  logic [TIME_W+3:0] rom [8];

  note_scheduler_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W), .NUM_SLOTS(NSLOT), .SLOT_W(SLOTW)) sif();

  note_scheduler #(
    .CHART_DEPTH(8), .ADDR_W(ADDR_W), .TIME_W(TIME_W),
    .LEAD_TICKS(100), .NUM_SLOTS(NSLOT), .SLOT_W(SLOTW)
  ) u_dut (
    .i_clock (clk),
    .i_resetn(rst_n),
    .io_sched(sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) sif.rom_data <= rom[sif.rom_addr];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic wait_spawn(input int max_cyc, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      if (sif.spawn_valid) hit = 1'b1;
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      if (sif.chart_done) hit = 1'b1;
    end
  endtask

  task automatic count_spawns(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (sif.spawn_valid) cnt++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    rom[0] = {32'd500, 4'b0001};
    rom[1] = {32'd500, 4'b0100};
    rom[2] = {32'd520, 4'b1000};
    rst_n            = 1'b0;
    sif.start        = 1'b0;
    sif.game_active  = 1'b0;
    sif.song_timer   = '0;
    sif.slot_release = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_addr",  sif.rom_addr,    0);
    check_eq("rst_vld",   sif.spawn_valid, 0);
    check_eq("rst_slot",  sif.spawn_slot,  0);
    check_eq("rst_lanes", sif.spawn_lanes, 0);
    check_eq("rst_time",  sif.spawn_time,  0);
    check_eq("rst_busy",  sif.slots_busy,  0);
    check_eq("rst_done",  sif.chart_done,  0);
`ifdef NOTE_SCHED_MISS_CNT_EN
    check_eq("rst_miss",  sif.miss_count,  0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Timer one tick short of the spawn window, then exactly on it.
    sif.game_active = 1'b1;
    sif.song_timer  = 399;
    pulse_start();
    count_spawns(10, n);
    check_eq("t1_early_none", n, 0);
    sif.song_timer = 400;
    wait_spawn(10, found);
    check_eq("t1_spawn1_seen", found, 1);
    check_eq("t1_spawn1_slot", sif.spawn_slot, 0);
    check_eq("t1_spawn1_lanes", sif.spawn_lanes, 4'b0001);
    check_eq("t1_spawn1_time", sif.spawn_time, 500);
    check_eq("t1_spawn1_busy", sif.slots_busy, 2'b01);
    @(negedge clk);
    check_eq("t1_pulse_one_cycle", sif.spawn_valid, 0);
    wait_spawn(10, found);
    check_eq("t1_spawn2_seen", found, 1);
    check_eq("t1_spawn2_slot", sif.spawn_slot, 1);
    check_eq("t1_spawn2_lanes", sif.spawn_lanes, 4'b0100);
    check_eq("t1_spawn2_busy", sif.slots_busy, 2'b11);

    // Third note due but no slot: stall until slot 0 is released.
    sif.song_timer = 420;
    count_spawns(8, n);
    check_eq("t2_stall_none", n, 0);
    check_eq("t2_stall_addr", sif.rom_addr, 2);
    check_eq("t2_stall_done", sif.chart_done, 0);
    sif.slot_release = 2'b01;
    @(negedge clk);
    sif.slot_release = '0;
    wait_spawn(6, found);
    check_eq("t2_spawn3_seen", found, 1);
    check_eq("t2_spawn3_slot", sif.spawn_slot, 0);
    check_eq("t2_spawn3_lanes", sif.spawn_lanes, 4'b1000);
    check_eq("t2_spawn3_time", sif.spawn_time, 520);
    wait_done(8, found);
    check_eq("t2_done_seen", found, 1);
    count_spawns(5, n);
    check_eq("t2_after_done_none", n, 0);
    check_eq("t2_done_held", sif.chart_done, 1);

    // Paused from start: fetch completes, CHECK holds at entry 0.
    sif.game_active = 1'b0;
    sif.song_timer  = 1000;
    pulse_start();
    count_spawns(10, n);
    check_eq("t3_pause_none", n, 0);
    check_eq("t3_pause_busy", sif.slots_busy, 0);
    check_eq("t3_pause_addr", sif.rom_addr, 0);
    check_eq("t3_pause_done", sif.chart_done, 0);
    sif.game_active = 1'b1;
    wait_spawn(4, found);
    check_eq("t3_resume1_seen", found, 1);
    check_eq("t3_resume1_lanes", sif.spawn_lanes, 4'b0001);
    wait_spawn(6, found);
    check_eq("t3_resume2_seen", found, 1);
    check_eq("t3_resume2_slot", sif.spawn_slot, 1);
    check_eq("t3_resume2_lanes", sif.spawn_lanes, 4'b0100);
`ifdef NOTE_SCHED_MISS_CNT_EN
    // Timer already past 520 with both slots held: the note is dropped.
    count_spawns(8, n);
    check_eq("t3_drop_none", n, 0);
    check_eq("t3_drop_miss", sif.miss_count, 1);
    check_eq("t3_drop_done", sif.chart_done, 1);
    check_eq("t3_drop_busy", sif.slots_busy, 2'b11);
`else
    count_spawns(6, n);
    check_eq("t3_full_stall", n, 0);
    sif.slot_release = 2'b11;
    @(negedge clk);
    sif.slot_release = '0;
    wait_spawn(6, found);
    check_eq("t3_resume3_seen", found, 1);
    check_eq("t3_resume3_slot", sif.spawn_slot, 0);
    check_eq("t3_resume3_lanes", sif.spawn_lanes, 4'b1000);
    check_eq("t3_resume3_busy", sif.slots_busy, 2'b01);
`endif

    // Start-to-spawn latency, then release of slot 1 in the allocation cycle.
    sif.game_active = 1'b1;
    sif.song_timer  = 400;
    pulse_start();
`ifdef NOTE_SCHED_MISS_CNT_EN
    check_eq("t4_miss_cleared", sif.miss_count, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_lat_before", sif.spawn_valid, 0);
    @(negedge clk);
    check_eq("t4_lat_at4", sif.spawn_valid, 1);
    check_eq("t4_lat_slot", sif.spawn_slot, 0);
    wait_spawn(6, found);
    check_eq("t4_spawn2_slot", sif.spawn_slot, 1);
    sif.slot_release = 2'b01;
    @(negedge clk);
    sif.slot_release = '0;
    count_spawns(4, n);
    check_eq("t4_wait_none", n, 0);
    check_eq("t4_busy_10", sif.slots_busy, 2'b10);
    sif.song_timer   = 420;
    sif.slot_release = 2'b10;
    @(negedge clk);
    sif.slot_release = '0;
    check_eq("t4_same_vld", sif.spawn_valid, 1);
    check_eq("t4_same_slot", sif.spawn_slot, 0);
    check_eq("t4_same_busy", sif.slots_busy, 2'b01);

    // Restart mid-chart with both slots busy.
    pulse_start();
    wait_spawn(6, found);
    wait_spawn(6, found);
    count_spawns(3, n);
    check_eq("t5_busy_full", sif.slots_busy, 2'b11);
    check_eq("t5_addr_2", sif.rom_addr, 2);
    pulse_start();
    check_eq("t5_start_busy", sif.slots_busy, 0);
    check_eq("t5_start_addr", sif.rom_addr, 0);
    check_eq("t5_start_done", sif.chart_done, 0);

    // Asynchronous reset while stalled in CHECK.
    wait_spawn(6, found);
    wait_spawn(6, found);
    count_spawns(3, n);
    check_eq("t5_pre_rst_time", sif.spawn_time, 500);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_arst_addr",  sif.rom_addr,    0);
    check_eq("t5_arst_busy",  sif.slots_busy,  0);
    check_eq("t5_arst_time",  sif.spawn_time,  0);
    check_eq("t5_arst_slot",  sif.spawn_slot,  0);
    check_eq("t5_arst_lanes", sif.spawn_lanes, 0);
    check_eq("t5_arst_vld",   sif.spawn_valid, 0);
    check_eq("t5_arst_done",  sif.chart_done,  0);
    @(negedge clk) rst_n = 1'b1;
    count_spawns(6, n);
    check_eq("t5_idle_none", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
